// File: rtl/ci_issue_master.sv
// Multicycle custom-instruction initiator: queues (n, a, b) commands, issues each to a slave with
// a one-cycle start pulse and returns the slave result on a valid/ready port. Watchdog: `CI_TIMEOUT_EN.
module ci_issue_master #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_n,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        ci_clk_en,
  output logic        ci_start,
  output logic [1:0]  ci_n,
  output logic [31:0] ci_dataa,
  output logic [31:0] ci_datab,
  input  logic [31:0] ci_result,
  input  logic        ci_done
);
  // state | meaning
  // IDLE  | no operation outstanding; pops the FIFO head when one is queued
  // ISSUE | ci_start high for this single cycle; ci_done ignored
  // WAIT  | waiting for ci_done (or the watchdog when enabled)
  // RESP  | response presented until rsp_ready
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int AW = $clog2(DEPTH);

  state_t      r_state;
  logic        r_alive;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [65:0] r_mem [DEPTH];
  logic        r_start;
  logic [1:0]  r_n;
  logic [31:0] r_dataa;
  logic [31:0] r_datab;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_result;
  logic        r_rsp_timeout;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic [65:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = cmd_valid && cmd_ready;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  // r_alive holds the ready/clock-enable outputs low until the first edge after reset release.
  assign cmd_ready   = r_alive && !w_full;
  assign ci_clk_en   = r_alive;
  assign ci_start    = r_start;
  assign ci_n        = r_n;
  assign ci_dataa    = r_dataa;
  assign ci_datab    = r_datab;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = (r_state != IDLE) || !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {cmd_n, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

`ifdef CI_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] r_timer;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_alive       <= 1'b0;
      r_rd_ptr      <= '0;
      r_start       <= 1'b0;
      r_n           <= '0;
      r_dataa       <= '0;
      r_datab       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_timeout <= 1'b0;
`ifdef CI_TIMEOUT_EN
      r_timer       <= '0;
`endif
    end else begin
      r_alive <= 1'b1;
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            {r_n, r_dataa, r_datab} <= w_head;
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_start  <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef CI_TIMEOUT_EN
          r_timer <= '0;
`endif
          r_state <= WAIT;
        end
        WAIT: begin
          if (ci_done) begin
            r_rsp_result  <= ci_result;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end
`ifdef CI_TIMEOUT_EN
          else if (r_timer == TO_LAST) begin
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
